// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand/start requests (master->unit) and hi/lo results, busy, done, div_zero (unit->master)
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a_in, b_in, hi_out, lo_out;
  logic mult_start, div_start, busy, done, div_zero;
  modport master (output a_in, b_in, mult_start, div_start, input hi_out, lo_out, busy, done, div_zero);
  modport slave (input a_in, b_in, mult_start, div_start, output hi_out, lo_out, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed Booth multiply / restoring divide; ports clk, rst (async active-low), bus (slave: a_in, b_in, mult_start, div_start -> hi_out, lo_out, busy, done, div_zero)
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  mult_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] hi_r, op_b, sum, shl, trial;
  logic [WIDTH-1:0] lo_r, abs_a, abs_b;
  logic qm1, is_div, neg_q, neg_r, dz, last, start;
  assign start = bus.mult_start || bus.div_start;
  assign last = cnt == CW'(WIDTH - 1);
  assign abs_a = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign abs_b = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  assign sum = {lo_r[0], qm1} == 2'b01 ? hi_r + op_b : {lo_r[0], qm1} == 2'b10 ? hi_r - op_b : hi_r;
  assign shl = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
  assign trial = shl - op_b;
  assign bus.busy = state == MULT || state == DIV;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (state == IDLE) next = bus.mult_start ? MULT : bus.div_start ? DIV : IDLE;
    else if (state == MULT) next = last ? FINISH : MULT;
    else if (state == DIV) next = dz || last ? FINISH : DIV;
    else next = IDLE;
  end
  // hi_r/lo_r hold {acc, multiplier} during MULT and {remainder, quotient} during DIV
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hi_r <= '0;
      lo_r <= '0;
      op_b <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      bus.hi_out <= '0;
      bus.lo_out <= '0;
      bus.done <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= state == FINISH;
      bus.div_zero <= state == FINISH && dz;
      case (state)
        IDLE: if (start) begin
          is_div <= !bus.mult_start;
          cnt <= '0;
          qm1 <= 1'b0;
          hi_r <= '0;
          op_b <= bus.mult_start ? {bus.a_in[WIDTH-1], bus.a_in} : {1'b0, abs_b};
          lo_r <= bus.mult_start ? bus.b_in : abs_a;
          neg_q <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
          neg_r <= bus.a_in[WIDTH-1];
          dz <= !bus.mult_start && bus.b_in == '0;
        end
        MULT: begin
          hi_r <= {sum[WIDTH], sum[WIDTH:1]};
          lo_r <= {sum[0], lo_r[WIDTH-1:1]};
          qm1 <= lo_r[0];
          cnt <= cnt + 1'b1;
        end
        DIV: if (!dz) begin
          hi_r <= trial[WIDTH] ? shl : trial;
          lo_r <= {lo_r[WIDTH-2:0], !trial[WIDTH]};
          cnt <= cnt + 1'b1;
        end
        FINISH: if (!dz) begin
          bus.hi_out <= is_div && neg_r ? -hi_r[WIDTH-1:0] : hi_r[WIDTH-1:0];
          bus.lo_out <= is_div && neg_q ? -lo_r : lo_r;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
  typedef struct {
    logic [31:0] hi, lo;
    logic dz;
    int acc, lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  int cyc = 0, errs = 0, checks = 0, busy_run = 0;
  logic [31:0] model_hi = '0, model_lo = '0;
  exp_t q[$];
  mult_div_unit_if #(.WIDTH(32)) bus ();
  mult_div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!rst) busy_run = 0;
    else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (q.size() == 0) check("spurious_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("hi", bus.hi_out, e.hi);
          check("lo", bus.lo_out, e.lo);
          check("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
          check("latency", cyc - e.acc, e.lat);
          check("busy_cycles", busy_run, e.lat - 1);
        end
        busy_run = 0;
      end else if (bus.div_zero) check("div_zero_without_done", 32'd1, 32'd0);
    end
  end
  task automatic issue(input bit mul, input logic [31:0] a, input logic [31:0] b, input bit both = 1'b0);
    exp_t e;
    longint p;
    int sa, sb;
    @(negedge clk);
    bus.a_in = a;
    bus.b_in = b;
    bus.mult_start = mul || both;
    bus.div_start = !mul || both;
    sa = $signed(a);
    sb = $signed(b);
    e.dz = 1'b0;
    e.lat = 33;
    if (mul || both) begin
      p = longint'(sa) * longint'(sb);
      model_hi = p[63:32];
      model_lo = p[31:0];
    end else if (sb == 0) begin
      e.dz = 1'b1;
      e.lat = 2;
    end else if (a == 32'h80000000 && sb == -1) begin
      model_hi = '0;
      model_lo = 32'h80000000;
    end else begin
      model_lo = sa / sb;
      model_hi = sa % sb;
    end
    e.hi = model_hi;
    e.lo = model_lo;
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.mult_start = 1'b0;
    bus.div_start = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("timeout", q.size(), 32'd0);
      q.delete();
    end
  endtask
  initial begin
    bus.a_in = '0;
    bus.b_in = '0;
    bus.mult_start = 1'b0;
    bus.div_start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", bus.hi_out, 32'd0);
    check("rst_lo", bus.lo_out, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    rst = 1'b1;
    issue(1, 32'd7, 32'hFFFFFFFD); wait_idle();
    issue(1, 32'h7FFFFFFF, 32'h7FFFFFFF); wait_idle();
    issue(1, 32'h80000000, 32'h80000000); wait_idle();
    issue(0, 32'hFFFFFFF9, 32'd2); wait_idle();
    issue(0, 32'd7, 32'hFFFFFFFE); wait_idle();
    issue(1, 32'd3, 32'd4); wait_idle();
    issue(0, 32'd5, 32'd0); wait_idle();
    issue(0, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    issue(1, 32'd6, 32'd2, 1'b1); wait_idle();
    issue(0, 32'd1000, 32'hFFFFFFF9);
    repeat (4) @(negedge clk);
    bus.a_in = 32'd11;
    bus.b_in = 32'd13;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    wait_idle();
    @(negedge clk);
    bus.a_in = 32'd123;
    bus.b_in = 32'd456;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_hi", bus.hi_out, 32'd0);
    check("async_rst_lo", bus.lo_out, 32'd0);
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.done}, 32'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1, 32'd9, 32'hFFFFFFFB); wait_idle();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      int r;
      r = $urandom_range(0, 7);
      a = r == 3 ? 32'h80000000 : $urandom;
      b = r == 0 ? 32'd0 : r == 1 ? 32'hFFFFFFFF : r == 2 ? 32'($urandom_range(0, 15)) : $urandom;
      issue(1'($urandom_range(0, 1)), a, b);
      wait_idle();
    end
    repeat (40) @(negedge clk);
    check("leftover_expectations", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Sequential signed multiply/divide unit for the multi-cycle MIPS-style datapath. It takes operands from the A/B operand registers and produces the HI and LO values that feed the high/low registers, which the mem-to-reg mux reads for mfhi/mflo. The control unit pulses a start signal and waits on done. Multiply uses radix-2 Booth; divide uses signed restoring division; both run one iteration per cycle.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH; hi_out/lo_out are WIDTH bits each.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  reset, asynchronous, active-low (clears all state when 0).
a_in  input  WIDTH  operand A (multiplicand / dividend), sampled only at an accepted start.
b_in  input  WIDTH  operand B (multiplier / divisor), sampled only at an accepted start.
mult_start  input  1  one-cycle request for a signed multiply.
div_start  input  1  one-cycle request for a signed divide.
hi_out  output  WIDTH  mult: product[2W-1:W]; div: remainder.
lo_out  output  WIDTH  mult: product[W-1:0]; div: quotient.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; hi_out/lo_out are valid from this cycle.
div_zero  output  1  one-cycle pulse, coincident with done, on a divide by zero.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; hi_out=0, lo_out=0, busy=0, done=0, div_zero=0; iteration counter=0. Reset mid-operation aborts the operation with no result write. The first start is accepted on the first rising edge after rst returns to 1.
- States: IDLE, MULT, DIV, FINISH.
- IDLE: a start is accepted only here. mult_start has priority if both starts are high. On the accepting edge, operands and the operation are latched, counter=0, busy=1, and the state moves to MULT or DIV. Later changes on a_in/b_in do not affect the result.
- Starts seen in any state other than IDLE are ignored and not queued.
- MULT: Booth step each edge over {acc[W], mplier[W], q_-1}: examine pair (q0,q_-1); 01 adds multiplicand to acc, 10 subtracts it; then arithmetic-shift right by 1. acc is W+1 bits to avoid overflow at -2^(W-1). After WIDTH steps, go to FINISH.
- DIV: operate on magnitudes |a| and |b|, with a WIDTH-step restoring loop: shift {rem,quo} left; trial rem-divisor; keep if non-negative and set quo bit. After WIDTH steps, go to FINISH.
- DIV sign fix in FINISH: quotient is negated if sign(a)!=sign(b); remainder takes the sign of a (truncation toward zero). -2^(W-1) / -1 yields lo=0x80000000, hi=0, with no flag.
- Divide by zero (b_in=0 at accept): no iterations. Next edge goes to FINISH with div_zero=1; hi_out/lo_out keep their previous values.
- FINISH (one cycle): write hi_out/lo_out (except div-by-zero), done=1, busy=0, then IDLE on the next edge.
- Normal latency: start accepted at edge k; done is high in the cycle after edge k+WIDTH+1. That is 33 clocks for WIDTH=32; div-by-zero takes 2 clocks.
- busy is high from the accepting edge until the edge entering FINISH. done and div_zero are registered pulses.
- A new start may be accepted in the cycle done is high, because the state is back to IDLE on that edge.
- hi_out/lo_out hold their last result indefinitely; no intermediate values are visible on them.

Test Plan:
1. mult a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 clocks after the accepting edge; busy high for 32 cycles.
2. mult a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001. Then a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
3. div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div a=7, b=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
4. Preload hi/lo via mult 3*4 (lo=12), then div a=5, b=0 -> done and div_zero high together 2 clocks after accept; hi=0, lo=12 unchanged.
5. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0. Assert mult_start and div_start together with a=6, b=2 -> multiply runs, lo=12.
6. Pulse mult_start at cycle 5 of a running divide -> ignored, and the divide result is correct. Drop rst low at iteration 10 of a multiply -> all outputs 0 immediately (asynchronous); a restart after rst=1 gives the correct result.
